riscv_mem_port_arb: RTL

- Parametrised N-port memory request arbiter and response router.
- Merges NUM_PORTS request ports (vc_MemReqMsg format) onto one memory request port.
- Returns each in-order response to the port that issued the matching request.
- Generalises the fixed two-imem-port scheme of the dual-issue core to any fetch width; also usable for imem+dmem sharing of a single memory.

---
 rtl/riscv_mem_port_arb.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_port_arb.sv
// -----------------------------------------------------------------------------
// riscv_mem_port_arb
//
// Merges NUM_PORTS memory request ports (vc_MemReqMsg format) onto a single
// memory request port and routes each in-order memory response back to the
// port that issued the matching request. A small tag FIFO remembers, in issue
// order, which port every outstanding request came from.
//
// Arbitration is round-robin by default. Defining RISCV_MEM_ARB_FIXED_PRIO_EN
// switches to fixed priority (lowest-indexed valid port wins). Use this for
// dual-issue fetch, where the older slot (port 0) must never be starved.
//
// Ports:
//   clk, reset    single clock domain; synchronous, active-high reset
//   inreq_msg     per-port request, port i at [i*REQ_SZ +: REQ_SZ]
//   inreq_val     per-port request valid
//   inreq_rdy     per-port request ready (one-hot or zero)
//   inresp_msg    per-port response; every slice carries memresp_msg
//   inresp_val    per-port response valid (one-hot or zero)
//   memreq_msg    merged request to memory
//   memreq_val    merged request valid
//   memreq_rdy    memory ready
//   memresp_msg   memory response
//   memresp_val   memory response valid (no back-pressure)
//   outstanding   current tag FIFO occupancy
//   resp_err      sticky: a response arrived with no outstanding tag
//
// Handshake semantics: a request transfers on a cycle where its val and rdy
// are both high. memreq_val never depends on memreq_rdy, so the memory side
// may derive its ready from our valid without a loop. Responses have no
// ready: a memresp_val pulse is consumed in that same cycle.
// -----------------------------------------------------------------------------
module riscv_mem_port_arb #(
    parameter int NUM_PORTS       = 2,
    parameter int PORT_W          = 1,
    parameter int REQ_SZ          = 67,
    parameter int RESP_SZ         = 35,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS*REQ_SZ-1:0]  inreq_msg,
    input  logic [NUM_PORTS-1:0]         inreq_val,
    output logic [NUM_PORTS-1:0]         inreq_rdy,
    output logic [NUM_PORTS*RESP_SZ-1:0] inresp_msg,
    output logic [NUM_PORTS-1:0]         inresp_val,
    output logic [REQ_SZ-1:0]            memreq_msg,
    output logic                         memreq_val,
    input  logic                         memreq_rdy,
    input  logic [RESP_SZ-1:0]           memresp_msg,
    input  logic                         memresp_val,
    output logic [CNT_W-1:0]             outstanding,
    output logic                         resp_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Tag FIFO: entry = index of the port that issued the request
    logic [PORT_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [PORT_W-1:0] head_tag;

    logic [PORT_W-1:0] gnt;
    logic              any_val;
    logic              full;
    logic              fire;
    logic              resp_ok;

`ifndef RISCV_MEM_ARB_FIXED_PRIO_EN
    logic [PORT_W-1:0] rr_ptr;
`endif

    // full is taken from the registered count, so a pop in the same cycle
    // does not open a slot for a push until the following cycle.
    assign any_val    = |inreq_val;
    assign full       = (count == CNT_W'(MAX_OUTSTANDING));
    assign memreq_val = any_val & ~full;
    assign fire       = memreq_val & memreq_rdy;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
`ifdef RISCV_MEM_ARB_FIXED_PRIO_EN
    always_comb begin : grant_fixed
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (inreq_val[i] && !found) begin
                gnt   = PORT_W'(i);
                found = 1'b1;
            end
        end
    end
`else
    // Pick the valid port with the smallest circular distance from rr_ptr.
    // Distances are computed in int so a non-power-of-two NUM_PORTS wraps
    // correctly.
    always_comb begin : grant_rr
        int d;
        int best_d;
        gnt    = '0;
        d      = 0;
        best_d = NUM_PORTS;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (inreq_val[i]) begin
                d = i - int'(rr_ptr);
                if (d < 0) begin
                    d = d + NUM_PORTS;
                end
                if (d < best_d) begin
                    best_d = d;
                    gnt    = PORT_W'(i);
                end
            end
        end
    end
`endif

    // Request mux and per-port ready
    always_comb begin
        memreq_msg = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt == PORT_W'(i)) begin
                memreq_msg = inreq_msg[i*REQ_SZ +: REQ_SZ];
            end
        end
    end

    always_comb begin
        inreq_rdy = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            inreq_rdy[i] = memreq_val && memreq_rdy && (gnt == PORT_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Response routing (zero latency)
    // ------------------------------------------------------------------
    // A response with an empty FIFO is dropped, even when a request fires
    // in that same cycle: the new tag is not visible until it is registered.
    assign resp_ok    = memresp_val && (count != '0);
    assign head_tag   = tag_mem[head];
    assign inresp_msg = {NUM_PORTS{memresp_msg}};

    always_comb begin
        inresp_val = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            inresp_val[i] = resp_ok && (head_tag == PORT_W'(i));
        end
    end

    assign outstanding = count;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    // Tag storage needs no reset: only entries between head and tail are read.
    always_ff @(posedge clk) begin
        if (!reset && fire) begin
            tag_mem[tail] <= gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (resp_ok) begin
                head <= head + PTR_W'(1);
            end
            if (fire && !resp_ok) begin
                count <= count + CNT_W'(1);
            end else if (!fire && resp_ok) begin
                count <= count - CNT_W'(1);
            end
            if (memresp_val && (count == '0)) begin
                resp_err <= 1'b1;
            end
        end
    end

`ifndef RISCV_MEM_ARB_FIXED_PRIO_EN
    // Pointer moves just past the winner; explicit wrap for odd port counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (fire) begin
            if (gnt == PORT_W'(NUM_PORTS - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt + PORT_W'(1);
            end
        end
    end
`endif

endmodule
